serial_sorter: RTL and testbench
================================

// Module: serial_sorter
// PURPOSE
//  Sequential sort engine built around a 3-bit compare-and-swap element.
//  Loads DEPTH unsigned words over a valid/ready input stream and sorts them
//  ascending using odd-even transposition, one phase per cycle.
//  Streams the sorted words out over a valid/ready output and reports the swap count.
//  Sits between the input word source and the downstream consumer of sorted values.
// PARAMETERS
//  WIDTH  3  bit width of each word, treated as unsigned
//  DEPTH  4  number of words per sort batch; must be >= 2
//  CNT_W  $clog2(DEPTH*(DEPTH-1)/2+1)  swap-count width (localparam, derived)
// PORTS
//  clk        in   1      single clock; all logic updates on its rising edge
//  rst        in   1      synchronous, active-high reset
//  in_data    in   WIDTH  input word
//  in_valid   in   1      in_data is valid
//  in_ready   out  1      high in LOAD; a word is taken when in_valid & in_ready
//  out_data   out  WIDTH  sorted word, smallest first
//  out_valid  out  1      high in DRAIN
//  out_ready  in   1      a word is consumed when out_valid & out_ready
//  busy       out  1      high in SORT or DRAIN
//  swap_cnt   out  CNT_W  swaps done on the current batch; valid from SORT exit through DRAIN
// BEHAVIOUR
//  - Reset values: state=LOAD, in_ready=1, out_valid=0, busy=0, swap_cnt=0,
//    out_data=0, load/drain index=0. Buffer contents don't care. Reset in any state
//    discards the batch and returns to LOAD.
//  - LOAD: each accepted word is written to buf[idx], then idx++.
//    On the DEPTH-th accept: go to SORT, set phase=0, clear swap_cnt.
//  - SORT: runs exactly DEPTH cycles, with no early exit. in_ready=0, out_valid=0.
//    Even phase: compare pairs (0,1),(2,3),... Odd phase: compare pairs (1,2),(3,4),...
//    Every pair with buf[i] > buf[i+1] swaps in the same cycle.
//    swap_cnt increases by the number of swaps in that phase.
//    Equal words never swap. Unpaired end elements hold their value.
//  - Latency: last input accepted at edge t. First out_valid is high after edge t+DEPTH.
//  - DRAIN: out_data=buf[idx] with idx starting at 0.
//    Each out handshake advances idx. out_data and out_valid hold while out_ready=0.
//    The handshake on buf[DEPTH-1] returns to LOAD with idx=0 and in_ready=1 next cycle.
//    swap_cnt holds until the next batch enters SORT.
//  - Inputs are ignored outside LOAD. in_valid while in_ready=0 has no effect.
//  - Arithmetic: comparisons are unsigned on WIDTH bits.
//    swap_cnt cannot overflow: the swap total equals the batch inversion count,
//    which is at most DEPTH*(DEPTH-1)/2.
// STRUCTURE
//  - Shared header sorter_defs.vh holds:
//    state encodings LOAD=2'd0, SORT=2'd1, DRAIN=2'd2;
//    default WIDTH and DEPTH; the CNT_W derivation.
//  - Sub-module cas_unit (combinational, WIDTH param): inputs a and b.
//    Outputs lo=min, hi=max, swp=(a>b).
//    Instantiated floor(DEPTH/2) times; even and odd phases select operand pairs via mux.
//  - Top level: FSM, index/phase counters, buffer register file, and a popcount of swp into swap_cnt.
// TESTING
//  1. Load 5,3,7,1 -> out 1,3,5,7; swap_cnt=4; first out_valid 4 cycles after last accept.
//  2. Load 0,1,2,3 -> out 0,1,2,3; swap_cnt=0; SORT still lasts 4 cycles.
//  3. Load 7,6,5,4 -> out 4,5,6,7; swap_cnt=6 (max).
//  4. Load 2,2,0,2 -> out 0,2,2,2; swap_cnt=2; equal words never swap.
//  5. Hold out_ready=0 for 3 cycles mid-DRAIN -> out_data and out_valid stable;
//     no word lost or duplicated; in_valid pulses during DRAIN are ignored.
//  6. Assert rst during SORT of 7,6,5,4 -> next cycle in_ready=1, busy=0, swap_cnt=0;
//     next batch 3,1,2,0 -> out 0,1,2,3; swap_cnt=5.
//  7. Back-to-back batches with in_valid held high -> each batch sorted independently.

Source files
------------

// File: rtl/serial_sorter_pkg.sv
// Shared definitions for the serial sorter: default sizes, state encoding
// and the swap-counter width derivation.
package serial_sorter_pkg;

  localparam int DEF_WIDTH = 3;
  localparam int DEF_DEPTH = 4;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Widest possible swap total is the batch's maximum inversion count.
  function automatic int cnt_w(input int depth);
    return $clog2(depth * (depth - 1) / 2 + 1);
  endfunction

endpackage

// File: rtl/serial_sorter_if.sv
// Stream bundle for the serial sorter: input word stream, sorted output
// stream and status.
interface serial_sorter_if
  import serial_sorter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
);
  localparam int CNT_W = cnt_w(DEPTH);

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic [CNT_W-1:0] swap_cnt;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, busy, swap_cnt
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, busy, swap_cnt
  );

endinterface

// File: rtl/serial_sorter_cas_unit.sv
// Combinational compare-and-swap element: orders two unsigned words and
// flags whether they were out of order.
module cas_unit #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             swp
);

  assign swp = (a > b);
  assign lo  = swp ? b : a;
  assign hi  = swp ? a : b;

endmodule

// File: rtl/serial_sorter.sv
// Batch sorter: loads DEPTH words, runs DEPTH odd-even transposition phases,
// then streams the words out smallest first with the batch swap count.
module serial_sorter
  import serial_sorter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic            clk,
  input  logic            rst,
  serial_sorter_if.slave  bus
);

  localparam int CNT_W = cnt_w(DEPTH);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int NPAIR = DEPTH / 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] idx_reg;
  logic [IDX_W-1:0] phase_reg;
  logic [CNT_W-1:0] swap_cnt_reg;
  logic [CNT_W-1:0] phase_swaps;
  logic [WIDTH-1:0] mem_reg    [DEPTH];
  logic [WIDTH-1:0] sorted_val [DEPTH];
  logic [WIDTH-1:0] cas_a [NPAIR];
  logic [WIDTH-1:0] cas_b [NPAIR];
  logic [WIDTH-1:0] cas_lo [NPAIR];
  logic [WIDTH-1:0] cas_hi [NPAIR];
  logic [NPAIR-1:0] cas_swp;
  logic             phase_odd;

  assign phase_odd = phase_reg[0];

  // Pair gi compares (2gi,2gi+1) on even phases and (2gi+1,2gi+2) on odd
  // phases; a pair with no right partner compares an element with itself.
  for (genvar gi = 0; gi < NPAIR; gi++) begin : g_pair
    localparam int OB = (2 * gi + 2 < DEPTH) ? 2 * gi + 2 : 2 * gi + 1;
    assign cas_a[gi] = phase_odd ? mem_reg[2*gi+1] : mem_reg[2*gi];
    assign cas_b[gi] = phase_odd ? mem_reg[OB]     : mem_reg[2*gi+1];
    cas_unit #(.WIDTH(WIDTH)) u_cas (
      .a   (cas_a[gi]),
      .b   (cas_b[gi]),
      .lo  (cas_lo[gi]),
      .hi  (cas_hi[gi]),
      .swp (cas_swp[gi])
    );
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_elem
    if (gi % 2 == 0) begin : g_even
      if (gi + 1 < DEPTH && gi > 0) begin : g_both
        assign sorted_val[gi] = phase_odd ? cas_hi[gi/2-1] : cas_lo[gi/2];
      end else if (gi + 1 < DEPTH) begin : g_first
        assign sorted_val[gi] = phase_odd ? mem_reg[gi] : cas_lo[gi/2];
      end else begin : g_tail
        assign sorted_val[gi] = phase_odd ? cas_hi[gi/2-1] : mem_reg[gi];
      end
    end else begin : g_odd
      if (gi + 1 < DEPTH) begin : g_mid
        assign sorted_val[gi] = phase_odd ? cas_lo[(gi-1)/2] : cas_hi[(gi-1)/2];
      end else begin : g_tail
        assign sorted_val[gi] = phase_odd ? mem_reg[gi] : cas_hi[(gi-1)/2];
      end
    end
  end

  always_comb begin
    phase_swaps = '0;
    for (int k = 0; k < NPAIR; k++) begin
      phase_swaps = phase_swaps + CNT_W'(cas_swp[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= LOAD;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next    = state_reg;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    bus.out_data  = '0;
    unique case (state_reg)
      LOAD: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid && idx_reg == LAST_IDX) state_next = SORT;
      end
      SORT: begin
        bus.busy = 1'b1;
        if (phase_reg == LAST_IDX) state_next = DRAIN;
      end
      DRAIN: begin
        bus.busy      = 1'b1;
        bus.out_valid = 1'b1;
        bus.out_data  = mem_reg[idx_reg];
        if (bus.out_ready && idx_reg == LAST_IDX) state_next = LOAD;
      end
      default: state_next = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_reg      <= '0;
      phase_reg    <= '0;
      swap_cnt_reg <= '0;
    end else begin
      unique case (state_reg)
        LOAD: if (bus.in_valid) begin
          mem_reg[idx_reg] <= bus.in_data;
          if (idx_reg == LAST_IDX) begin
            idx_reg      <= '0;
            phase_reg    <= '0;
            swap_cnt_reg <= '0;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        SORT: begin
          for (int i = 0; i < DEPTH; i++) mem_reg[i] <= sorted_val[i];
          swap_cnt_reg <= swap_cnt_reg + phase_swaps;
          phase_reg    <= (phase_reg == LAST_IDX) ? '0 : phase_reg + 1'b1;
        end
        DRAIN: if (bus.out_ready) begin
          idx_reg <= (idx_reg == LAST_IDX) ? '0 : idx_reg + 1'b1;
        end
        default: idx_reg <= '0;
      endcase
    end
  end

  assign bus.swap_cnt = swap_cnt_reg;

endmodule

// File: tb/tb_serial_sorter.sv
// Self-checking bench for serial_sorter: directed and random batches checked
// against a queue-sort / inversion-count reference.
module tb_serial_sorter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   failed = 0;

  serial_sorter_if bus ();

  serial_sorter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Loads one batch, measures latency, drains with an optional 3-cycle stall
  // before word stall_at, and checks everything against the reference.
  task automatic run_batch(input string name, input int w0, input int w1,
                           input int w2, input int w3, input int stall_at,
                           input bit hold_valid);
    int w[4];
    int q[$];
    int inv;
    int lat;
    w = '{w0, w1, w2, w3};
    q = {};
    inv = 0;
    foreach (w[i]) q.push_back(w[i]);
    q.sort();
    for (int i = 0; i < 4; i++)
      for (int j = i + 1; j < 4; j++)
        if (w[i] > w[j]) inv++;

    for (int i = 0; i < 4; i++) begin
      bus.in_data  = 3'(w[i]);
      bus.in_valid = 1'b1;
      check({name, " in_ready"}, 32'(bus.in_ready), 1);
      step();
    end
    if (hold_valid) bus.in_data = 3'($urandom_range(0, 7));
    else            bus.in_valid = 1'b0;
    check({name, " sort busy"}, 32'(bus.busy), 1);
    check({name, " sort in_ready"}, 32'(bus.in_ready), 0);

    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      step();
      lat++;
    end
    check({name, " latency"}, lat, 4);
    check({name, " swap_cnt"}, 32'(bus.swap_cnt), inv);

    for (int i = 0; i < 4; i++) begin
      if (i == stall_at) begin
        bus.out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          bus.in_valid = 1'b1;
          bus.in_data  = 3'($urandom_range(0, 7));
          step();
          check({name, " stall out_valid"}, 32'(bus.out_valid), 1);
          check({name, " stall out_data"}, 32'(bus.out_data), q[i]);
        end
        bus.in_valid = hold_valid;
      end
      bus.out_ready = 1'b1;
      check({name, " out_valid"}, 32'(bus.out_valid), 1);
      check({name, " out_data"}, 32'(bus.out_data), q[i]);
      step();
    end
    bus.out_ready = 1'b0;
    if (!hold_valid) bus.in_valid = 1'b0;
    check({name, " done in_ready"}, 32'(bus.in_ready), 1);
    check({name, " done busy"}, 32'(bus.busy), 0);
    check({name, " done out_valid"}, 32'(bus.out_valid), 0);
    check({name, " held swap_cnt"}, 32'(bus.swap_cnt), inv);
    $display("[TB] batch %s: in %0d %0d %0d %0d -> out %0d %0d %0d %0d swaps %0d",
             name, w0, w1, w2, w3, q[0], q[1], q[2], q[3], inv);
  endtask

  initial begin
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    check("reset in_ready", 32'(bus.in_ready), 1);
    check("reset out_valid", 32'(bus.out_valid), 0);
    check("reset busy", 32'(bus.busy), 0);
    check("reset swap_cnt", 32'(bus.swap_cnt), 0);
    check("reset out_data", 32'(bus.out_data), 0);
    $display("[TB] reset released");

    run_batch("t1", 5, 3, 7, 1, -1, 1'b0);
    run_batch("t2", 0, 1, 2, 3, -1, 1'b0);
    run_batch("t3", 7, 6, 5, 4, -1, 1'b0);
    run_batch("t4", 2, 2, 0, 2, -1, 1'b0);
    run_batch("t5 stall", 6, 0, 4, 2, 1, 1'b0);

    // Reset in the middle of sorting discards the batch.
    for (int i = 0; i < 4; i++) begin
      bus.in_data  = 3'(7 - i);
      bus.in_valid = 1'b1;
      step();
    end
    bus.in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6 rst in_ready", 32'(bus.in_ready), 1);
    check("t6 rst busy", 32'(bus.busy), 0);
    check("t6 rst swap_cnt", 32'(bus.swap_cnt), 0);
    check("t6 rst out_valid", 32'(bus.out_valid), 0);
    $display("[TB] reset during sort applied");
    run_batch("t6", 3, 1, 2, 0, -1, 1'b0);

    run_batch("t7a", 4, 1, 6, 1, -1, 1'b1);
    run_batch("t7b", 0, 7, 3, 5, 2, 1'b1);
    run_batch("t7c", 7, 7, 7, 0, -1, 1'b0);

    for (int r = 0; r < 8; r++) begin
      run_batch("rnd", int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                int'($urandom_range(0, 5)) - 1, 1'($urandom_range(0, 1)));
    end
    bus.in_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
